bitonic_sched: RTL and testbench
================================

// Module: bitonic_sched
// PURPOSE
//  Issue controller for the 4-input bitonic sorter pipeline.
//  - Accepts 4-element groups on a valid/ready stream and issues them to the sorter with ctrl valid/last.
//  - Captures sorted groups into an output FIFO. The sorter cannot stall, so a credit counter guarantees FIFO space before each issue.
//  - Tracks frames (in_last_i) and signals frame completion for the top-k merge stage.
// PARAMETERS
//  DATAWIDTH   8  bits per element
//  SORT_LAT    3  fixed sorter latency, issue cycle to result cycle (>=1)
//  FIFO_DEPTH  8  output FIFO entries (power of 2, >=SORT_LAT+1)
// PORTS
//  clk_i         in   1            clock
//  rst_i         in   1            synchronous reset, active-high
//  in_valid_i    in   1            input group valid
//  in_ready_o    out  1            input group accepted when valid&ready
//  in_last_i     in   1            last group of frame
//  in_data_i     in   4*DATAWIDTH  4 unsorted elements, element 0 at LSBs
//  sort_valid_o  out  1            ctrl valid to sorter
//  sort_last_o   out  1            ctrl last to sorter
//  sort_data_o   out  4*DATAWIDTH  group to sorter
//  sort_valid_i  in   1            ctrl valid returned by sorter
//  sort_last_i   in   1            ctrl last returned by sorter
//  sort_data_i   in   4*DATAWIDTH  sorted group from sorter
//  out_valid_o   out  1            output group valid
//  out_ready_i   in   1            downstream ready
//  out_last_o    out  1            last group of frame
//  out_data_o    out  4*DATAWIDTH  sorted group
//  frame_done_o  out  1            1-cycle pulse: last group of frame popped
//  busy_o        out  1            state!=IDLE or FIFO non-empty
//  err_o         out  1            sticky protocol error
// BEHAVIOUR
//  Reset: all outputs 0 except in_ready_o=1. credit=FIFO_DEPTH, FIFO empty, state IDLE, err_o cleared.
//  Credit:
//   - issue = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i.
//   - credit -1 on issue, +1 on pop. Simultaneous issue+pop leaves credit unchanged.
//   - Credit never exceeds FIFO_DEPTH and never drops below 0.
//  in_ready_o = (state!=DRAIN) & (credit!=0 | pop). Combinational pop bypass allows issue at credit=0 with a same-cycle pop.
//  Issue: sort_*_o are registered and follow an issue by 1 cycle. sort_valid_o=0 in non-issue cycles; sort_data_o holds its last value.
//  Capture: sort_valid_i=1 writes {sort_last_i, sort_data_i} into the FIFO.
//  FIFO: first-word fallthrough. out_valid_o rises the cycle after the write. Simultaneous write and pop are allowed at any fill level.
//  Latency: accept at cycle N -> sort_valid_o at N+1 -> out_valid_o at N+2+SORT_LAT, given an empty FIFO.
//  FSM:
//   - IDLE->RUN on the first issue.
//   - RUN->DRAIN on an issue with in_last_i=1.
//   - Issue with in_last_i=1 from IDLE goes directly to DRAIN.
//   - DRAIN->IDLE on a pop with out_last_o=1. frame_done_o pulses in that same cycle.
//   - DRAIN holds in_ready_o=0, so frames never overlap.
//  Errors (err_o sticky until reset):
//   - sort_valid_i while the FIFO is full: the beat is dropped.
//   - sort_valid_i with 0 groups outstanding (issued minus captured).
//  Reset mid-frame: everything returns to reset values in 1 cycle. Sorter results still in flight after reset are counted as the "0 outstanding" error and dropped.
// CONFIGURATION
//  BITONIC_SCHED_PERF_EN defined adds these ports, cleared by rst_i:
//   - stall_cnt_o out 32: count of cycles with in_valid_i & ~in_ready_o.
//   - group_cnt_o out 32: count of issues.
//   - Both counters saturate at 2^32-1.
//  BITONIC_SCHED_PERF_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1. Single group {3,1,4,2}, last=1, out_ready_i=1 -> sort_valid_o at cycle 1, out_valid_o at cycle 5, out_last_o=1, frame_done_o pulse, state IDLE.
//  2. 12 back-to-back groups, out_ready_i=0 -> exactly 8 accepted, then in_ready_o=0. Raising out_ready_i resumes 1 group/cycle with no drop or reorder.
//  3. FIFO full, credit=0, out_ready_i=1 and in_valid_i=1 in the same cycle -> issue accepted, credit stays 0.
//  4. Frame of 3 groups with last on the third, 4th group pending -> 4th blocked until the frame_done_o pulse, accepted the cycle after.
//  5. rst_i asserted with 2 groups in flight -> outputs at reset values next cycle. Late sort_valid_i sets err_o=1 and nothing enters the FIFO.
//  6. BITONIC_SCHED_PERF_EN: 5 stall cycles and 10 issues -> stall_cnt_o=5, group_cnt_o=10.

Source files
------------

// File: rtl/bitonic_sched.sv
// Issue controller for the 4-input bitonic sorter: credit-gated issue, FWFT result FIFO, frame tracking.
// Optional performance counters are built when BITONIC_SCHED_PERF_EN is defined.
module bitonic_sched #(
  parameter int unsigned DATAWIDTH  = 8,
  parameter int unsigned SORT_LAT   = 3,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic                   in_last_i,
  input  logic [4*DATAWIDTH-1:0] in_data_i,
  output logic                   sort_valid_o,
  output logic                   sort_last_o,
  output logic [4*DATAWIDTH-1:0] sort_data_o,
  input  logic                   sort_valid_i,
  input  logic                   sort_last_i,
  input  logic [4*DATAWIDTH-1:0] sort_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic                   out_last_o,
  output logic [4*DATAWIDTH-1:0] out_data_o,
  output logic                   frame_done_o,
  output logic                   busy_o,
  output logic                   err_o
`ifdef BITONIC_SCHED_PERF_EN
  ,
  output logic [31:0]            stall_cnt_o,
  output logic [31:0]            group_cnt_o
`endif
);

  localparam int unsigned GW = 4 * DATAWIDTH;
  localparam int unsigned EW = GW + 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned OW = $clog2(FIFO_DEPTH + SORT_LAT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   credit_q, credit_d;
  logic [OW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            err_q, err_d;
  logic            sort_valid_q, sort_valid_d;
  logic            sort_last_q, sort_last_d;
  logic [GW-1:0]   sort_data_q, sort_data_d;
  logic [EW-1:0]   fifo_mem_q [FIFO_DEPTH];

  logic            fifo_empty_c, fifo_full_c;
  logic [EW-1:0]   head_c;
  logic            pop_c, issue_c, no_outst_c, overflow_c, cap_c, wr_en_c;

  // FIFO head view and handshake decode
  always_comb begin
    fifo_empty_c = (count_q == '0);
    fifo_full_c  = (count_q == CW'(FIFO_DEPTH));
    head_c       = fifo_mem_q[rd_ptr_q];
    out_valid_o  = !fifo_empty_c;
    out_last_o   = !fifo_empty_c && head_c[GW];
    out_data_o   = fifo_empty_c ? '0 : head_c[GW-1:0];
    pop_c        = out_valid_o && out_ready_i;
    in_ready_o   = (state_q != ST_DRAIN) && ((credit_q != '0) || pop_c);
    issue_c      = in_valid_i && in_ready_o;
    no_outst_c   = (outst_q == '0);
    // A full FIFO can still take a beat in the cycle it is popped
    overflow_c   = fifo_full_c && !pop_c;
    cap_c        = sort_valid_i && !no_outst_c;
    wr_en_c      = cap_c && !overflow_c;
    frame_done_o = (state_q == ST_DRAIN) && pop_c && out_last_o;
    busy_o       = (state_q != ST_IDLE) || !fifo_empty_c;
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    credit_d     = credit_q;
    outst_d      = outst_q;
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    err_d        = err_q;
    sort_valid_d = issue_c;
    sort_last_d  = issue_c && in_last_i;
    sort_data_d  = sort_data_q;

    if (issue_c) sort_data_d = in_data_i;

    if (issue_c && !pop_c && (credit_q != '0)) begin
      credit_d = credit_q - CW'(1);
    end else if (!issue_c && pop_c && (credit_q < CW'(FIFO_DEPTH))) begin
      credit_d = credit_q + CW'(1);
    end

    if (issue_c && !cap_c) begin
      outst_d = outst_q + OW'(1);
    end else if (!issue_c && cap_c) begin
      outst_d = outst_q - OW'(1);
    end

    count_d = count_q + CW'(wr_en_c) - CW'(pop_c);
    if (wr_en_c) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_c)   rd_ptr_d = rd_ptr_q + PW'(1);

    if (sort_valid_i && (no_outst_c || overflow_c)) err_d = 1'b1;

    case (state_q)
      ST_IDLE:  if (issue_c) state_d = in_last_i ? ST_DRAIN : ST_RUN;
      ST_RUN:   if (issue_c && in_last_i) state_d = ST_DRAIN;
      ST_DRAIN: if (pop_c && out_last_o) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      credit_q     <= CW'(FIFO_DEPTH);
      outst_q      <= '0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      err_q        <= 1'b0;
      sort_valid_q <= 1'b0;
      sort_last_q  <= 1'b0;
      sort_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      credit_q     <= credit_d;
      outst_q      <= outst_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      err_q        <= err_d;
      sort_valid_q <= sort_valid_d;
      sort_last_q  <= sort_last_d;
      sort_data_q  <= sort_data_d;
    end
  end

  // Storage is data-only; validity comes from count_q
  always_ff @(posedge clk_i) begin
    if (wr_en_c) fifo_mem_q[wr_ptr_q] <= {sort_last_i, sort_data_i};
  end

  assign sort_valid_o = sort_valid_q;
  assign sort_last_o  = sort_last_q;
  assign sort_data_o  = sort_data_q;
  assign err_o        = err_q;

`ifdef BITONIC_SCHED_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] group_cnt_q, group_cnt_d;

  // Saturating event counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    group_cnt_d = group_cnt_q;
    if (in_valid_i && !in_ready_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'(1);
    if (issue_c && (group_cnt_q != '1)) group_cnt_d = group_cnt_q + 32'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      group_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      group_cnt_q <= group_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign group_cnt_o = group_cnt_q;
`else
  // Performance counters are not built in this configuration
`endif

endmodule

// File: tb/tb_bitonic_sched.sv
// Bench for bitonic_sched: behavioural sorter, cycle-level scoreboard, directed frame/credit/reset cases.
module tb_bitonic_sched;

  localparam int DW    = 8;
  localparam int SORT_LAT   = 3;
  localparam int FIFO_DEPTH = 8;
  localparam int GW    = 4 * DW;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          in_valid_i, in_ready_o, in_last_i;
  logic [GW-1:0] in_data_i;
  logic          sort_valid_o, sort_last_o;
  logic [GW-1:0] sort_data_o;
  logic          sort_valid_i, sort_last_i;
  logic [GW-1:0] sort_data_i;
  logic          out_valid_o, out_ready_i, out_last_o;
  logic [GW-1:0] out_data_o;
  logic          frame_done_o, busy_o, err_o;
`ifdef BITONIC_SCHED_PERF_EN
  logic [31:0]   stall_cnt_o, group_cnt_o;
`endif

  bitonic_sched #(.DATAWIDTH(DW), .SORT_LAT(SORT_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_last_i(in_last_i), .in_data_i(in_data_i),
    .sort_valid_o(sort_valid_o), .sort_last_o(sort_last_o), .sort_data_o(sort_data_o),
    .sort_valid_i(sort_valid_i), .sort_last_i(sort_last_i), .sort_data_i(sort_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_last_o(out_last_o), .out_data_o(out_data_o),
    .frame_done_o(frame_done_o), .busy_o(busy_o), .err_o(err_o)
`ifdef BITONIC_SCHED_PERF_EN
    , .stall_cnt_o(stall_cnt_o), .group_cnt_o(group_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Ascending 4-element sort, element 0 at the LSBs
  function automatic logic [GW-1:0] sort4(input logic [GW-1:0] d);
    logic [DW-1:0] e [4];
    logic [DW-1:0] t;
    for (int i = 0; i < 4; i++) e[i] = d[i*DW +: DW];
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3 - i; j++)
        if (e[j] > e[j+1]) begin t = e[j]; e[j] = e[j+1]; e[j+1] = t; end
    return {e[3], e[2], e[1], e[0]};
  endfunction

  // Behavioural sorter: fixed latency, never stalls, ignores rst_i
  logic          pv [SORT_LAT];
  logic          pl [SORT_LAT];
  logic [GW-1:0] pd [SORT_LAT];
  logic          inj_v, inj_l;
  logic [GW-1:0] inj_d;

  always @(posedge clk_i) begin
    pv[0] <= sort_valid_o;
    pl[0] <= sort_last_o;
    pd[0] <= sort4(sort_data_o);
    for (int i = 1; i < SORT_LAT; i++) begin
      pv[i] <= pv[i-1];
      pl[i] <= pl[i-1];
      pd[i] <= pd[i-1];
    end
  end

  assign sort_valid_i = pv[SORT_LAT-1] | inj_v;
  assign sort_last_i  = inj_v ? inj_l : pl[SORT_LAT-1];
  assign sort_data_i  = inj_v ? inj_d : pd[SORT_LAT-1];

  // Reference model: each accepted group becomes visible 2+SORT_LAT cycles later, in order
  typedef struct {
    logic [GW-1:0] d;
    logic          l;
    int            rdy;
  } ent_t;

  ent_t          exp_q[$];
  logic          drain_m = 1'b0;
  logic          frame_m = 1'b0;
  logic          prev_iss = 1'b0;
  logic [GW-1:0] prev_d = '0;
  int            n_pops = 0;
  int            last_done_cyc = -1;

  always @(negedge clk_i) begin : mon
    logic ov, pp, ir, fd, iss;
    if (rst_i) begin
      exp_q.delete();
      drain_m  = 1'b0;
      frame_m  = 1'b0;
      prev_iss = 1'b0;
    end else begin
      ov = (exp_q.size() > 0) && (exp_q[0].rdy <= cyc);
      pp = ov && out_ready_i;
      ir = !drain_m && ((exp_q.size() < FIFO_DEPTH) || pp);
      fd = pp ? exp_q[0].l : 1'b0;
      chk("in_ready", in_ready_o, ir);
      chk("out_valid", out_valid_o, ov);
      chk("sort_valid", sort_valid_o, prev_iss);
      if (prev_iss) chk("sort_data", sort_data_o, prev_d);
      chk("busy", busy_o, frame_m || ov);
      chk("frame_done", frame_done_o, fd);
      if (ov) begin
        chk("out_data", out_data_o, exp_q[0].d);
        chk("out_last", out_last_o, exp_q[0].l);
      end
      if (frame_done_o) last_done_cyc = cyc;
      if (pp) begin
        if (exp_q[0].l) begin drain_m = 1'b0; frame_m = 1'b0; end
        void'(exp_q.pop_front());
        n_pops++;
      end
      iss = in_valid_i && ir;
      if (iss) begin
        exp_q.push_back('{d: sort4(in_data_i), l: in_last_i, rdy: cyc + 2 + SORT_LAT});
        frame_m = 1'b1;
        if (in_last_i) drain_m = 1'b1;
      end
      prev_iss = iss;
      prev_d   = in_data_i;
    end
  end

  task automatic do_reset();
    rst_i = 1'b1; in_valid_i = 1'b0; in_last_i = 1'b0; in_data_i = '0;
    out_ready_i = 1'b0; inj_v = 1'b0; inj_l = 1'b0; inj_d = '0;
    repeat (SORT_LAT + 3) @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Holds one group valid until accepted; returns the accept cycle or -1
  task automatic send(input logic [GW-1:0] d, input logic l, output int acc);
    in_valid_i = 1'b1; in_data_i = d; in_last_i = l; acc = -1;
    for (int k = 0; k < 64 && acc < 0; k++) begin
      @(negedge clk_i);
      if (in_ready_o) acc = cyc;
      next_cycle();
    end
    in_valid_i = 1'b0; in_last_i = 1'b0;
    chk("send_accepted", 64'(acc >= 0), 64'(1));
  endtask

  typedef struct {
    logic          iv, il, ordy;
    logic [GW-1:0] din;
    logic          e_ir, e_sv, e_ov, e_ol, e_fd, e_busy;
    logic [GW-1:0] e_data;
  } vec_t;

  vec_t          vecs [7];
  logic [GW-1:0] gv [12];
  int            a, a1, a8, a10, a12, extra, pops0;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // Single group {3,1,4,2} with last, out_ready high
    vecs[0] = '{1'b1, 1'b1, 1'b1, 32'h02040103, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h02040103};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h04030201};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    for (int i = 0; i < 12; i++) gv[i] = $urandom;

    do_reset();
    @(negedge clk_i);
    chk("rst_in_ready", in_ready_o, 1'b1);
    chk("rst_out_valid", out_valid_o, 1'b0);
    chk("rst_sort_valid", sort_valid_o, 1'b0);
    chk("rst_sort_data", sort_data_o, '0);
    chk("rst_out_data", out_data_o, '0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    next_cycle();

    for (int i = 0; i < 7; i++) begin
      in_valid_i = vecs[i].iv; in_last_i = vecs[i].il;
      out_ready_i = vecs[i].ordy; in_data_i = vecs[i].din;
      @(negedge clk_i);
      chk("t1_in_ready", in_ready_o, vecs[i].e_ir);
      chk("t1_sort_valid", sort_valid_o, vecs[i].e_sv);
      chk("t1_out_valid", out_valid_o, vecs[i].e_ov);
      chk("t1_out_last", out_last_o, vecs[i].e_ol);
      chk("t1_frame_done", frame_done_o, vecs[i].e_fd);
      chk("t1_busy", busy_o, vecs[i].e_busy);
      if (vecs[i].e_sv) chk("t1_sort_data", sort_data_o, vecs[i].e_data);
      if (vecs[i].e_ov) chk("t1_out_data", out_data_o, vecs[i].e_data);
      next_cycle();
    end

    // Back-to-back groups against a stalled output: credit limit, pop bypass, no drop or reorder
    do_reset();
    pops0 = n_pops;
    for (int i = 0; i < 8; i++) begin
      send(gv[i], 1'b0, a);
      if (i == 0) a1 = a;
      if (i == 7) a8 = a;
    end
    chk("t2_eight_consecutive", 64'(a8 - a1), 64'(7));
    in_valid_i = 1'b1; in_data_i = gv[8]; extra = 0;
    repeat (20) begin
      @(negedge clk_i);
      if (in_ready_o) extra++;
      next_cycle();
    end
    chk("t2_ninth_blocked", 64'(extra), 64'(0));
    out_ready_i = 1'b1;
    @(negedge clk_i);
    chk("t3_full_pop_bypass", in_ready_o, 1'b1);
    next_cycle();
    out_ready_i = 1'b0; in_data_i = gv[9];
    @(negedge clk_i);
    chk("t3_credit_still_zero", in_ready_o, 1'b0);
    next_cycle();
    out_ready_i = 1'b1;
    send(gv[9], 1'b0, a10);
    send(gv[10], 1'b0, a);
    send(gv[11], 1'b1, a12);
    chk("t2_resume_rate", 64'(a12 - a10), 64'(2));
    for (int k = 0; k < 40 && busy_o; k++) next_cycle();
    chk("t2_pop_count", 64'(n_pops - pops0), 64'(12));
    chk("t2_idle", busy_o, 1'b0);

    // Next frame held off until the previous frame's last group pops
    do_reset();
    out_ready_i = 1'b1;
    send(gv[0], 1'b0, a);
    send(gv[1], 1'b0, a);
    send(gv[2], 1'b1, a1);
    send(gv[3], 1'b0, a);
    chk("t4_done_after_last", 64'(last_done_cyc > a1), 64'(1));
    chk("t4_accept_after_done", 64'(a), 64'(last_done_cyc + 1));

    // Reset with two groups in flight; late results must be flagged and dropped
    do_reset();
    send(gv[4], 1'b0, a);
    send(gv[5], 1'b0, a);
    rst_i = 1'b1;
    next_cycle();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("t5_in_ready", in_ready_o, 1'b1);
    chk("t5_sort_valid", sort_valid_o, 1'b0);
    chk("t5_out_valid", out_valid_o, 1'b0);
    chk("t5_busy", busy_o, 1'b0);
    chk("t5_err_clear", err_o, 1'b0);
    next_cycle();
    repeat (5) next_cycle();
    @(negedge clk_i);
    chk("t5_err_set", err_o, 1'b1);
    chk("t5_fifo_empty", out_valid_o, 1'b0);
    next_cycle();

    // Result beat arriving while the FIFO is full and stalled
    do_reset();
    pops0 = n_pops;
    for (int i = 0; i < 8; i++) send(gv[i], 1'b0, a);
    repeat (8) next_cycle();
    @(negedge clk_i);
    chk("ovf_err_before", err_o, 1'b0);
    next_cycle();
    inj_v = 1'b1; inj_l = 1'b1; inj_d = 32'hdeadbeef;
    next_cycle();
    inj_v = 1'b0;
    @(negedge clk_i);
    chk("ovf_err_set", err_o, 1'b1);
    next_cycle();
    out_ready_i = 1'b1;
    repeat (15) next_cycle();
    chk("ovf_pop_count", 64'(n_pops - pops0), 64'(8));
    chk("ovf_empty", out_valid_o, 1'b0);

`ifdef BITONIC_SCHED_PERF_EN
    do_reset();
    for (int i = 0; i < 8; i++) send(gv[i], 1'b0, a);
    in_valid_i = 1'b1; in_data_i = gv[8];
    repeat (5) next_cycle();
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    repeat (15) next_cycle();
    send(gv[9], 1'b0, a);
    send(gv[10], 1'b0, a);
    @(negedge clk_i);
    chk("perf_stall_cnt", 64'(stall_cnt_o), 64'(5));
    chk("perf_group_cnt", 64'(group_cnt_o), 64'(10));
    next_cycle();
`endif

    // Random traffic checked cycle by cycle by the reference model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      in_valid_i  = ($urandom_range(0, 9) < 7);
      in_last_i   = ($urandom_range(0, 7) == 0);
      in_data_i   = $urandom;
      out_ready_i = ($urandom_range(0, 9) < 6);
      next_cycle();
    end
    in_valid_i = 1'b0; in_last_i = 1'b0; out_ready_i = 1'b1;
    repeat (30) next_cycle();
    @(negedge clk_i);
    chk("rand_drained", out_valid_o, 1'b0);
    chk("rand_no_err", err_o, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
